// File: rtl/cpu_pkg.sv
// Shared definitions for the bus CPU control path: control-word bit map,
// idle word, opcode encoding and sequencer state.
package cpu_pkg;

    localparam int unsigned CTRL_W = 15;

    localparam int unsigned BIT_CP   = 14;
    localparam int unsigned BIT_EP   = 13;
    localparam int unsigned BIT_LP   = 12;
    localparam int unsigned BIT_NLMA = 11;
    localparam int unsigned BIT_NLMD = 10;
    localparam int unsigned BIT_NCE  = 9;
    localparam int unsigned BIT_NLR  = 8;
    localparam int unsigned BIT_NLI  = 7;
    localparam int unsigned BIT_NEI  = 6;
    localparam int unsigned BIT_NLA  = 5;
    localparam int unsigned BIT_EA   = 4;
    localparam int unsigned BIT_SUB  = 3;
    localparam int unsigned BIT_EU   = 2;
    localparam int unsigned BIT_NLB  = 1;
    localparam int unsigned BIT_NLO  = 0;

    // Active-low strobes high, active-high strobes low.
    localparam logic [CTRL_W-1:0] CTRL_IDLE = 15'h0FE3;

    typedef enum logic [3:0] {
        OpNop = 4'h0,
        OpLda = 4'h1,
        OpAdd = 4'h2,
        OpSub = 4'h3,
        OpLdi = 4'h4,
        OpOut = 4'h5,
        OpJmp = 4'h6,
        OpJc  = 4'h7,
        OpJz  = 4'h8,
        OpHlt = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        StPause = 2'd0,
        StRun   = 2'd1,
        StHalt  = 2'd2
    } state_e;

endpackage

// File: rtl/microcode_rom.sv
// Combinational microcode: maps (opcode, T index, flags) to the control word
// for that T-state and flags the final T-state of the instruction.
module microcode_rom
    import cpu_pkg::*;
#(
    parameter int unsigned TW = 3
) (
    input  logic [3:0]        opcode,
    input  logic [TW-1:0]     t,
    input  logic              cf,
    input  logic              zf,
    output logic [CTRL_W-1:0] ctrl_word,
    output logic              last
);

    opcode_e op;
    assign op = opcode_e'(opcode);

    always_comb begin
        ctrl_word = CTRL_IDLE;
        last      = 1'b0;
        if (t == TW'(0)) begin
            ctrl_word[BIT_EP]   = 1'b1;
            ctrl_word[BIT_NLMA] = 1'b0;
        end else if (t == TW'(1)) begin
            ctrl_word[BIT_CP]  = 1'b1;
            ctrl_word[BIT_NCE] = 1'b0;
            ctrl_word[BIT_NLI] = 1'b0;
            // Conditional jumps decide here whether a T2 exists at all.
            case (op)
                OpLda, OpAdd, OpSub, OpLdi, OpOut, OpJmp: last = 1'b0;
                OpJc:    last = ~cf;
                OpJz:    last = ~zf;
                default: last = 1'b1;
            endcase
        end else begin
            case (op)
                OpLda: begin
                    if (t == TW'(2)) begin
                        ctrl_word[BIT_NEI]  = 1'b0;
                        ctrl_word[BIT_NLMA] = 1'b0;
                    end else begin
                        ctrl_word[BIT_NCE] = 1'b0;
                        ctrl_word[BIT_NLA] = 1'b0;
                        last               = 1'b1;
                    end
                end
                OpAdd, OpSub: begin
                    if (t == TW'(2)) begin
                        ctrl_word[BIT_NEI]  = 1'b0;
                        ctrl_word[BIT_NLMA] = 1'b0;
                    end else if (t == TW'(3)) begin
                        ctrl_word[BIT_NCE] = 1'b0;
                        ctrl_word[BIT_NLB] = 1'b0;
                        ctrl_word[BIT_SUB] = (op == OpSub);
                    end else begin
                        ctrl_word[BIT_EU]  = 1'b1;
                        ctrl_word[BIT_NLA] = 1'b0;
                        ctrl_word[BIT_SUB] = (op == OpSub);
                        last               = 1'b1;
                    end
                end
                OpLdi: begin
                    ctrl_word[BIT_NEI] = 1'b0;
                    ctrl_word[BIT_NLA] = 1'b0;
                    last               = 1'b1;
                end
                OpOut: begin
                    ctrl_word[BIT_EA]  = 1'b1;
                    ctrl_word[BIT_NLO] = 1'b0;
                    last               = 1'b1;
                end
                OpJmp, OpJc, OpJz: begin
                    ctrl_word[BIT_NEI] = 1'b0;
                    ctrl_word[BIT_LP]  = 1'b1;
                    last               = 1'b1;
                end
                default: last = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/microsequencer.sv
// Control sequencer: PAUSE/RUN/HALT state, T-state counter and single-step
// edge detector wrapped around the microcode ROM.
module microsequencer
    import cpu_pkg::*;
#(
    parameter int unsigned  NUM_T   = 6,
    parameter bit           STEP_EN = 1'b1,
    localparam int unsigned TW      = $clog2(NUM_T)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        opcode,
    input  logic              cf,
    input  logic              zf,
    input  logic              step_mode,
    input  logic              step,
    output logic [CTRL_W-1:0] ctrl,
    output logic [TW-1:0]     t_state,
    output logic              halted,
    output logic              fetch
);

    state_e            state_q, state_d;
    logic [TW-1:0]     t_q, t_d;
    logic              step_q;
    logic              step_mode_eff, step_eff, step_rise;
    logic [CTRL_W-1:0] rom_ctrl;
    logic              rom_last, end_instr;

    if (STEP_EN) begin : g_step
        assign step_mode_eff = step_mode;
        assign step_eff      = step;
    end else begin : g_no_step
        assign step_mode_eff = 1'b0;
        assign step_eff      = 1'b0;
    end

    assign step_rise = step_eff & ~step_q;

    microcode_rom #(
        .TW(TW)
    ) u_rom (
        .opcode    (opcode),
        .t         (t_q),
        .cf        (cf),
        .zf        (zf),
        .ctrl_word (rom_ctrl),
        .last      (rom_last)
    );

    // The guard keeps a malformed microprogram from running off the counter.
    assign end_instr = rom_last || (t_q == TW'(NUM_T - 1));

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        unique case (state_q)
            StPause: begin
                t_d = '0;
                if (!step_mode_eff || step_rise) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (end_instr) begin
                    t_d = '0;
                    if (opcode_e'(opcode) == OpHlt) begin
                        state_d = StHalt;
                    end else if (step_mode_eff) begin
                        state_d = StPause;
                    end
                end else begin
                    t_d = t_q + TW'(1);
                end
            end
            StHalt: t_d = '0;
            default: begin
                state_d = StPause;
                t_d     = '0;
            end
        endcase
    end

    // Step edges seen during RUN update step_q but are otherwise dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StPause;
            t_q     <= '0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            step_q  <= step_eff;
        end
    end

    assign ctrl    = (state_q == StRun) ? rom_ctrl : CTRL_IDLE;
    assign t_state = t_q;
    assign halted  = (state_q == StHalt);
    assign fetch   = (state_q == StRun) && (t_q == '0);

endmodule

// File: tb/tb_microsequencer.sv
// Self-checking bench for microsequencer: directed vector table, hand-written
// corner sequences and randomized instruction streams against a reference model.
module tb_microsequencer;

    localparam int unsigned TW = 3;
    localparam logic [14:0] IDLE = 15'h0FE3;
    localparam logic [14:0] T0W  = 15'h27E3;
    localparam logic [14:0] T1W  = 15'h4D63;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  opcode = 4'h0;
    logic        cf = 1'b0;
    logic        zf = 1'b0;
    logic        step_mode = 1'b0;
    logic        step = 1'b0;
    logic [14:0] ctrl;
    logic [TW-1:0] t_state;
    logic        halted;
    logic        fetch;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    microsequencer #(
        .NUM_T   (6),
        .STEP_EN (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .opcode    (opcode),
        .cf        (cf),
        .zf        (zf),
        .step_mode (step_mode),
        .step      (step),
        .ctrl      (ctrl),
        .t_state   (t_state),
        .halted    (halted),
        .fetch     (fetch)
    );

    typedef struct {
        logic [3:0]       op;
        logic             c;
        logic             z;
        int               len;
        logic [4:0][14:0] w;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(input logic [3:0] op, input logic c, input logic z,
                                input int len, input logic [14:0] a2, input logic [14:0] a3,
                                input logic [14:0] a4);
        vec_t v;
        v.op   = op;
        v.c    = c;
        v.z    = z;
        v.len  = len;
        v.w[0] = T0W;
        v.w[1] = T1W;
        v.w[2] = a2;
        v.w[3] = a3;
        v.w[4] = a4;
        return v;
    endfunction

    // Reference model: instruction length and per-T words from the opcode table.
    function automatic int model_len(input logic [3:0] op, input logic c, input logic z);
        case (op)
            4'h1: return 4;
            4'h2, 4'h3: return 5;
            4'h4, 4'h5, 4'h6: return 3;
            4'h7: return c ? 3 : 2;
            4'h8: return z ? 3 : 2;
            default: return 2;
        endcase
    endfunction

    function automatic logic [14:0] model_word(input logic [3:0] op, input int i);
        logic [14:0] add_seq[3];
        logic [14:0] sub_seq[3];
        add_seq = '{15'h07A3, 15'h0DE1, 15'h0FC7};
        sub_seq = '{15'h07A3, 15'h0DE9, 15'h0FCF};
        if (i == 0) return T0W;
        if (i == 1) return T1W;
        case (op)
            4'h1: return (i == 2) ? 15'h07A3 : 15'h0DC3;
            4'h2: return add_seq[i-2];
            4'h3: return sub_seq[i-2];
            4'h4: return 15'h0F83;
            4'h5: return 15'h0FF2;
            default: return 15'h1FA3;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1 time unit into the first PAUSE cycle after reset.
    task automatic do_reset(input logic [3:0] op, input logic c, input logic z,
                            input logic sm);
        rst       = 1'b1;
        opcode    = op;
        cf        = c;
        zf        = z;
        step_mode = sm;
        step      = 1'b0;
        next_cycle();
        rst = 1'b0;
    endtask

    initial begin
        int nrun;
        int nfetch;
        int len;
        int k;
        logic [3:0] op;
        logic c;
        logic z;
        logic sm;

        #1;
        check("reset_ctrl", ctrl, IDLE);
        check("reset_t", t_state, 0);
        check("reset_halted", halted, 0);
        check("reset_fetch", fetch, 0);

        vecs[0]  = mk(4'h0, 0, 0, 2, 0, 0, 0);
        vecs[1]  = mk(4'h1, 0, 0, 4, 15'h07A3, 15'h0DC3, 0);
        vecs[2]  = mk(4'h2, 0, 0, 5, 15'h07A3, 15'h0DE1, 15'h0FC7);
        vecs[3]  = mk(4'h3, 1, 1, 5, 15'h07A3, 15'h0DE9, 15'h0FCF);
        vecs[4]  = mk(4'h4, 0, 0, 3, 15'h0F83, 0, 0);
        vecs[5]  = mk(4'h5, 0, 0, 3, 15'h0FF2, 0, 0);
        vecs[6]  = mk(4'h6, 0, 0, 3, 15'h1FA3, 0, 0);
        vecs[7]  = mk(4'h7, 0, 1, 2, 0, 0, 0);
        vecs[8]  = mk(4'h7, 1, 0, 3, 15'h1FA3, 0, 0);
        vecs[9]  = mk(4'h8, 1, 0, 2, 0, 0, 0);
        vecs[10] = mk(4'h8, 0, 1, 3, 15'h1FA3, 0, 0);
        vecs[11] = mk(4'hA, 1, 1, 2, 0, 0, 0);
        vecs[12] = mk(4'hD, 0, 0, 2, 0, 0, 0);
        vecs[13] = mk(4'hF, 0, 0, 2, 0, 0, 0);

        foreach (vecs[n]) begin
            do_reset(vecs[n].op, vecs[n].c, vecs[n].z, 1'b0);
            @(negedge clk);
            check("vec_pause", ctrl, IDLE);
            next_cycle();
            for (int i = 0; i < vecs[n].len; i++) begin
                @(negedge clk);
                check($sformatf("vec%0d_ctrl_t%0d", n, i), ctrl, vecs[n].w[i]);
                check($sformatf("vec%0d_tstate", n), t_state, i);
                next_cycle();
            end
            @(negedge clk);
            if (vecs[n].op == 4'hF) begin
                check("hlt_halted", halted, 1);
                check("hlt_ctrl", ctrl, IDLE);
            end else begin
                check($sformatf("vec%0d_next_fetch", n), fetch, 1);
                check($sformatf("vec%0d_next_t0", n), ctrl, T0W);
            end
        end

        // HALT holds through step toggles; only rst leaves it.
        do_reset(4'hF, 0, 0, 1'b0);
        next_cycle();
        next_cycle();
        next_cycle();
        for (int j = 0; j < 20; j++) begin
            step = ~step;
            @(negedge clk);
            check("halt_hold_ctrl", ctrl, IDLE);
            check("halt_hold_flag", halted, 1);
            next_cycle();
        end
        rst = 1'b1;
        #1;
        check("halt_rst_clear", halted, 0);
        check("halt_rst_t", t_state, 0);

        // Held-high step releases exactly one instruction.
        do_reset(4'h1, 0, 0, 1'b1);
        @(negedge clk);
        check("step_pause0", ctrl, IDLE);
        next_cycle();
        step   = 1'b1;
        nrun   = 0;
        nfetch = 0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            if (ctrl !== IDLE) nrun++;
            if (fetch === 1'b1) nfetch++;
            next_cycle();
        end
        check("step_held_run_cycles", nrun, 4);
        check("step_held_fetches", nfetch, 1);
        step = 1'b0;
        @(negedge clk);
        check("step_low_idle", ctrl, IDLE);
        next_cycle();
        step = 1'b1;
        @(negedge clk);
        check("step_edge_cycle_idle", ctrl, IDLE);
        next_cycle();
        @(negedge clk);
        check("step_edge_fetch", fetch, 1);
        check("step_edge_t0", ctrl, T0W);

        // step_mode raised mid-instruction pauses at the following boundary.
        do_reset(4'h1, 0, 0, 1'b0);
        next_cycle();
        next_cycle();
        step_mode = 1'b1;
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("sm_mid_last", ctrl, 15'h0DC3);
        next_cycle();
        @(negedge clk);
        check("sm_mid_paused", ctrl, IDLE);
        check("sm_mid_nofetch", fetch, 0);

        // Asynchronous reset in ADD T3 idles the outputs without a clock.
        do_reset(4'h2, 0, 0, 1'b0);
        for (int j = 0; j < 4; j++) next_cycle();
        #1;
        check("add_t3_ctrl", ctrl, 15'h0DE1);
        check("add_t3_t", t_state, 3);
        rst = 1'b1;
        #1;
        check("async_rst_ctrl", ctrl, IDLE);
        check("async_rst_t", t_state, 0);

        // Randomized instruction stream with random step-mode pauses.
        do_reset(4'h0, 0, 0, 1'b0);
        @(negedge clk);
        check("rnd_first_pause", ctrl, IDLE);
        next_cycle();
        for (int n = 0; n < 300; n++) begin
            op        = 4'($urandom_range(0, 14));
            c         = 1'($urandom_range(0, 1));
            z         = 1'($urandom_range(0, 1));
            sm        = ($urandom_range(0, 3) == 0);
            opcode    = op;
            cf        = c;
            zf        = z;
            step_mode = sm;
            len       = model_len(op, c, z);
            for (int i = 0; i < len; i++) begin
                step = 1'($urandom_range(0, 1));
                @(negedge clk);
                check("rnd_ctrl", ctrl, model_word(op, i));
                check("rnd_t", t_state, i);
                check("rnd_fetch", fetch, (i == 0));
                next_cycle();
            end
            if (sm) begin
                k = $urandom_range(1, 4);
                for (int j = 0; j < k; j++) begin
                    step = 1'b0;
                    @(negedge clk);
                    check("rnd_pause_idle", ctrl, IDLE);
                    next_cycle();
                end
                step = 1'b1;
                @(negedge clk);
                check("rnd_pause_edge", ctrl, IDLE);
                next_cycle();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
